// File: rtl/sdcard_spi_byte_if.sv
// ---------------------------------------------------------------------------
// sdcard_spi_byte_if
// Byte-level handshake between the SD-card boot loader (master) and the SPI
// byte engine (slave).
//   tx_start  loader -> engine  request a byte transfer (taken only when idle)
//   tx_data   loader -> engine  byte to send, MSB first
//   slow      loader -> engine  1: slow SCLK divider for this byte
//   cs_assert loader -> engine  1: chip select low while idle
//   busy      engine -> loader  transfer / init sequence in progress
//   rx_valid  engine -> loader  1-cycle pulse, rx_data holds received byte
//   rx_data   engine -> loader  last received byte
//   init_req  loader -> engine  start init clock burst (SDSPI_INIT_CLOCKS_EN)
//   init_done engine -> loader  1-cycle pulse at end of init (SDSPI_INIT_CLOCKS_EN)
// ---------------------------------------------------------------------------
interface sdcard_spi_byte_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       slow;
  logic       cs_assert;
  logic       busy;
  logic       rx_valid;
  logic [7:0] rx_data;
`ifdef SDSPI_INIT_CLOCKS_EN
  logic       init_req;
  logic       init_done;

  modport master (output tx_start, tx_data, slow, cs_assert, init_req,
                  input  busy, rx_valid, rx_data, init_done);
  modport slave  (input  tx_start, tx_data, slow, cs_assert, init_req,
                  output busy, rx_valid, rx_data, init_done);
`else
  modport master (output tx_start, tx_data, slow, cs_assert,
                  input  busy, rx_valid, rx_data);
  modport slave  (input  tx_start, tx_data, slow, cs_assert,
                  output busy, rx_valid, rx_data);
`endif
endinterface

// File: rtl/sdcard_spi_byte.sv
// ---------------------------------------------------------------------------
// sdcard_spi_byte
// SPI mode-0 byte engine for the SD-card boot loader. Accepts one byte at a
// time over the bus interface, owns all SCLK timing, and returns the byte
// shifted in on MISO.
// Ports:
//   i_clk          system clock
//   i_rst_n        synchronous active-low reset
//   bus            sdcard_spi_byte_if.slave (loader handshake)
//   o_sdcard_cs    chip select, active low
//   o_sdcard_sclk  SPI clock, idles low
//   o_sdcard_mosi  SPI data out, idles high
//   i_sdcard_miso  SPI data in
// Optional feature: define SDSPI_INIT_CLOCKS_EN to add the init clock burst
// (INIT_CLOCKS pulses at SLOW_DIV with cs high and mosi high).
// ---------------------------------------------------------------------------
module sdcard_spi_byte #(
  parameter int CLK_DIV     = 4,
  parameter int SLOW_DIV    = 128,
  parameter int INIT_CLOCKS = 80
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  sdcard_spi_byte_if.slave  bus,
  output logic              o_sdcard_cs,
  output logic              o_sdcard_sclk,
  output logic              o_sdcard_mosi,
  input  logic              i_sdcard_miso
);

  localparam logic [7:0] FAST_M1 = 8'(CLK_DIV - 1);
  localparam logic [7:0] SLOW_M1 = 8'(SLOW_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_DONE, S_INIT, S_INIT_DONE
  } state_t;

  state_t     r_state, w_next;
  logic [7:0] r_cnt, r_div_m1, r_tx_sh, r_rx_sh, r_rx_data;
  logic [2:0] r_bit;
  logic       r_sclk, r_mosi, r_cs;
  logic       w_idle, w_accept, w_init_accept, w_edge, w_init_last;

  // DONE and INIT_DONE are non-busy cycles, so a new request may start there.
  assign w_idle = (r_state == S_IDLE) || (r_state == S_DONE) ||
                  (r_state == S_INIT_DONE);
  assign w_edge = (r_cnt == 8'd0);

`ifdef SDSPI_INIT_CLOCKS_EN
  logic [15:0] r_pulse;

  // Init beats a simultaneous tx_start.
  assign w_init_accept = w_idle && bus.init_req;
  assign w_init_last   = w_edge && r_sclk && (r_pulse == 16'(INIT_CLOCKS - 1));
  assign bus.init_done = (r_state == S_INIT_DONE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      r_pulse <= '0;
    else if (w_init_accept)
      r_pulse <= '0;
    else if (r_state == S_INIT && w_edge && r_sclk)
      r_pulse <= r_pulse + 16'd1;
  end
`else
  assign w_init_accept = 1'b0;
  assign w_init_last   = 1'b0;
`endif

  assign w_accept = w_idle && bus.tx_start && !w_init_accept;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_INIT_DONE: begin
        if (w_init_accept) w_next = S_INIT;
        else if (w_accept) w_next = S_SHIFT;
        else               w_next = S_IDLE;
      end
      S_SHIFT: if (w_edge && r_sclk && r_bit == 3'd7) w_next = S_DONE;
      S_INIT:  if (w_init_last) w_next = S_INIT_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b1;
      r_cs      <= 1'b1;
      r_rx_data <= 8'd0;
      r_cnt     <= 8'd0;
      r_bit     <= 3'd0;
    end else if (w_init_accept) begin
      r_cs     <= 1'b1;
      r_mosi   <= 1'b1;
      r_sclk   <= 1'b0;
      r_div_m1 <= SLOW_M1;
      r_cnt    <= SLOW_M1;
    end else if (w_accept) begin
      // Byte parameters are latched here; later input changes do not matter.
      r_tx_sh  <= bus.tx_data;
      r_mosi   <= bus.tx_data[7];
      r_sclk   <= 1'b0;
      r_div_m1 <= bus.slow ? SLOW_M1 : FAST_M1;
      r_cnt    <= bus.slow ? SLOW_M1 : FAST_M1;
      r_bit    <= 3'd0;
    end else if (w_idle) begin
      // cs only follows cs_assert between transfers.
      r_cs <= ~bus.cs_assert;
    end else if (!w_edge) begin
      r_cnt <= r_cnt - 8'd1;
    end else begin
      r_cnt <= r_div_m1;
      if (!r_sclk) begin
        // Rising edge: take the miso value present during the last low cycle.
        r_sclk <= 1'b1;
        if (r_state == S_SHIFT) r_rx_sh <= {r_rx_sh[6:0], i_sdcard_miso};
      end else begin
        r_sclk <= 1'b0;
        if (r_state == S_SHIFT) begin
          if (r_bit == 3'd7) begin
            r_mosi    <= 1'b1;
            r_rx_data <= r_rx_sh;
          end else begin
            r_mosi  <= r_tx_sh[6];
            r_tx_sh <= {r_tx_sh[6:0], 1'b0};
          end
          r_bit <= r_bit + 3'd1;
        end
      end
    end
  end

  assign bus.busy     = (r_state == S_SHIFT) || (r_state == S_INIT);
  assign bus.rx_valid = (r_state == S_DONE);
  assign bus.rx_data  = r_rx_data;
  assign o_sdcard_cs   = r_cs;
  assign o_sdcard_sclk = r_sclk;
  assign o_sdcard_mosi = r_mosi;

endmodule

// File: tb/tb_sdcard_spi_byte.sv
module tb_sdcard_spi_byte;
  localparam int DIV = 2, SDIV = 4, NINIT = 80;

  logic clk = 1'b0;
  logic rst_n;
  logic sclk, cs, mosi, miso;

  sdcard_spi_byte_if bus();

  sdcard_spi_byte #(.CLK_DIV(DIV), .SLOW_DIV(SDIV), .INIT_CLOCKS(NINIT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus),
    .o_sdcard_cs(cs), .o_sdcard_sclk(sclk), .o_sdcard_mosi(mosi),
    .i_sdcard_miso(miso)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every rx_valid must match the next expected byte.
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_unexpected: got rx_data %0h expected no rx_valid", bus.rx_data);
      end else begin
        check("rx_data", bus.rx_data, exp_q.pop_front());
      end
    end
  end

  // SPI slave model (mode 0): bit 7 presented up front, next bit after each fall.
  logic [7:0] slv_byte = 8'hFF;
  int fall_cnt = 0, fall_base = 0, rise_cnt = 0, slv_idx;
  logic [7:0] mosi_log = 8'h00;
  always @(negedge sclk) fall_cnt++;
  always @(posedge sclk) begin
    rise_cnt++;
    mosi_log = {mosi_log[6:0], mosi};
  end
  assign slv_idx = fall_cnt - fall_base;
  assign miso = (slv_idx >= 0 && slv_idx < 8) ? slv_byte[3'(7 - slv_idx)] : 1'b1;

  task automatic load_slave(input logic [7:0] b);
    slv_byte  = b;
    fall_base = fall_cnt;
  endtask

  // Returns 1 ns after the accepting edge (cycle 0); next negedge is cycle 1.
  task automatic launch(input logic [7:0] d, input logic s);
    @(negedge clk);
    bus.tx_data  = d;
    bus.slow     = s;
    bus.tx_start = 1'b1;
    @(posedge clk);
    #1 bus.tx_start = 1'b0;
  endtask

  task automatic watch(input int n, output int busy_n, output int first_rv,
                       output int rv_n, output int cs_hi);
    busy_n = 0; first_rv = 0; rv_n = 0; cs_hi = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      busy_n += int'(bus.busy);
      cs_hi  += int'(cs);
      if (bus.rx_valid) begin
        rv_n++;
        if (first_rv == 0) first_rv = k;
      end
    end
  endtask

  int bn, fr, rn, ch, r0;

  initial begin
    rst_n = 1'b0;
    bus.tx_start = 1'b0; bus.tx_data = 8'h00; bus.slow = 1'b0; bus.cs_assert = 1'b0;
`ifdef SDSPI_INIT_CLOCKS_EN
    bus.init_req = 1'b0;
`endif
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs", cs, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_rx_data", bus.rx_data, 0);
    rst_n = 1'b1;

    // Basic byte A5 -> 3C at DIV=2
    bus.cs_assert = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_cs_low", cs, 0);
    load_slave(8'h3C); exp_q.push_back(8'h3C); r0 = rise_cnt;
    launch(8'hA5, 1'b0);
    watch(40, bn, fr, rn, ch);
    check("a5_busy_cycles", bn, 32);
    check("a5_rx_valid_cycle", fr, 33);
    check("a5_rx_valid_count", rn, 1);
    check("a5_cs_high_cycles", ch, 0);
    check("a5_rises", rise_cnt - r0, 8);
    check("a5_mosi_bits", mosi_log, 8'hA5);
    check("a5_idle_mosi", mosi, 1);

    // Back-to-back: FF then 00 started in the rx_valid cycle
    load_slave(8'h81); exp_q.push_back(8'h81); exp_q.push_back(8'h7E); r0 = rise_cnt;
    launch(8'hFF, 1'b0);
    for (int k = 1; k <= 33; k++) @(negedge clk);
    check("b2b_first_valid", bus.rx_valid, 1);
    load_slave(8'h7E);
    bus.tx_data = 8'h00; bus.tx_start = 1'b1;
    @(posedge clk);
    #1 bus.tx_start = 1'b0;
    @(negedge clk);
    check("b2b_busy_next", bus.busy, 1);
    check("b2b_sclk_low", sclk, 0);
    watch(40, bn, fr, rn, ch);
    check("b2b_second_valid_cycle", fr, 32);
    check("b2b_valid_total", rn + 1, 2);
    check("b2b_rises", rise_cnt - r0, 16);
    check("b2b_mosi_bits", mosi_log, 8'h00);

    // tx_start (and slow/data change) mid-byte is ignored
    load_slave(8'h5A); exp_q.push_back(8'h5A);
    launch(8'hA5, 1'b0);
    bn = 0; fr = 0; rn = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 5) begin bus.tx_start = 1'b1; bus.tx_data = 8'h00; bus.slow = 1'b1; end
      if (k == 6) bus.tx_start = 1'b0;
      bn += int'(bus.busy);
      if (bus.rx_valid) begin rn++; if (fr == 0) fr = k; end
    end
    bus.slow = 1'b0;
    check("ign_busy_cycles", bn, 32);
    check("ign_rx_valid_cycle", fr, 33);
    check("ign_rx_valid_count", rn, 1);
    check("ign_mosi_bits", mosi_log, 8'hA5);

    // Reset mid-transfer at cycle 10
    load_slave(8'h34);
    launch(8'h12, 1'b0);
    for (int k = 1; k <= 10; k++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_sclk", sclk, 0);
    check("mid_rst_mosi", mosi, 1);
    check("mid_rst_cs", cs, 1);
    check("mid_rst_rx_valid", bus.rx_valid, 0);
    check("mid_rst_rx_data", bus.rx_data, 0);
    rst_n = 1'b1;
    watch(40, bn, fr, rn, ch);
    check("mid_rst_no_valid", rn, 0);
    load_slave(8'h96); exp_q.push_back(8'h96);
    launch(8'hC3, 1'b0);
    watch(40, bn, fr, rn, ch);
    check("post_rst_valid_cycle", fr, 33);
    check("post_rst_mosi_bits", mosi_log, 8'hC3);

    // Slow byte uses SLOW_DIV
    load_slave(8'hE7); exp_q.push_back(8'hE7);
    launch(8'h5B, 1'b1);
    watch(80, bn, fr, rn, ch);
    check("slow_busy_cycles", bn, 64);
    check("slow_rx_valid_cycle", fr, 65);
    check("slow_mosi_bits", mosi_log, 8'h5B);

`ifdef SDSPI_INIT_CLOCKS_EN
    // Init burst wins over a simultaneous tx_start
    begin
      int cs_lo, mosi_lo, done_at, done_n;
      cs_lo = 0; mosi_lo = 0; done_at = 0; done_n = 0; bn = 0; rn = 0;
      r0 = rise_cnt;
      @(negedge clk);
      bus.init_req = 1'b1; bus.tx_start = 1'b1; bus.tx_data = 8'h00;
      @(posedge clk);
      #1 begin bus.init_req = 1'b0; bus.tx_start = 1'b0; end
      for (int k = 1; k <= 700; k++) begin
        @(negedge clk);
        bn += int'(bus.busy);
        if (bus.rx_valid) rn++;
        if (k <= 2 * SDIV * NINIT) begin
          cs_lo   += int'(!cs);
          mosi_lo += int'(!mosi);
        end
        if (bus.init_done) begin done_n++; if (done_at == 0) done_at = k; end
      end
      check("init_busy_cycles", bn, 2 * SDIV * NINIT);
      check("init_done_cycle", done_at, 2 * SDIV * NINIT + 1);
      check("init_done_count", done_n, 1);
      check("init_rises", rise_cnt - r0, NINIT);
      check("init_cs_low_cycles", cs_lo, 0);
      check("init_mosi_low_cycles", mosi_lo, 0);
      check("init_rx_valid_count", rn, 0);
      check("init_cs_after", cs, 0);
    end
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
